// File: rtl/shifter_pkg.sv
// shifter_pkg: op and FSM state encodings shared by the iterative shifter
package shifter_pkg;
  typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROR = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_e;
endpackage

// File: rtl/shift_step.sv
// shift_step: one-position shift of a word plus the bit that leaves it
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] data_o,
  output logic             bit_o
);
  // SLL drops the MSB, every right-going op drops the LSB (ROR also reinserts it at the top)
  always_comb begin
    data_o = (op_i == OP_SLL) ? {data_i[WIDTH-2:0], 1'b0} :
             (op_i == OP_SRL) ? {1'b0, data_i[WIDTH-1:1]} :
             (op_i == OP_SRA) ? {data_i[WIDTH-1], data_i[WIDTH-1:1]} :
                                {data_i[0], data_i[WIDTH-1:1]};
    bit_o  = (op_i == OP_SLL) ? data_i[WIDTH-1] : data_i[0];
  end
endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter moving one bit position per clock
module iter_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);
  state_e           state_q;
  op_e              op_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             last_q;
  logic [WIDTH-1:0] step_data;
  logic             step_bit;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .data_i(data_q),
    .op_i  (op_q),
    .data_o(step_data),
    .bit_o (step_bit)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_last  = last_q;

  // Capture in IDLE, shift one step per SHIFT cycle, hold the result in DONE until taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_SLL;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          data_q  <= in_data;
          op_q    <= op_e'(in_op);
          cnt_q   <= in_amt;
          last_q  <= 1'b0;
          state_q <= (in_amt == '0) ? DONE : SHIFT;
        end
        SHIFT: begin
          data_q  <= step_data;
          last_q  <= step_bit;
          cnt_q   <= cnt_q - 1'b1;
          state_q <= (cnt_q == SHW'(1)) ? DONE : SHIFT;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed and random checks of 4- and 32-bit shifters against an operator model
module tb_iter_shifter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [4:0]  in_amt = '0;
  logic [1:0]  in_op = '0;
  logic        out_ready = 1'b0;
  logic        ir4, ov4, ol4, ir32, ov32, ol32;
  logic [3:0]  od4;
  logic [31:0] od32;
  logic        ir, ov, ol;
  logic [31:0] od;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  iter_shifter #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid & ~sel), .in_ready(ir4),
    .in_data(in_data[3:0]), .in_amt(in_amt[1:0]), .in_op(in_op),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_last(ol4)
  );

  iter_shifter #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid & sel), .in_ready(ir32),
    .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
    .out_valid(ov32), .out_ready(out_ready), .out_data(od32), .out_last(ol32)
  );

  assign ir = sel ? ir32 : ir4;
  assign ov = sel ? ov32 : ov4;
  assign ol = sel ? ol32 : ol4;
  assign od = sel ? od32 : {28'b0, od4};

  function automatic logic [32:0] model(input int w, input logic [31:0] d, input int a, input logic [1:0] op);
    logic [63:0] m, x, r;
    logic        last;
    m = (64'h1 << w) - 64'h1;
    x = {32'b0, d} & m;
    case (op)
      2'b00:   r = (x << a) & m;
      2'b01:   r = x >> a;
      2'b10:   r = (x >> a) | (x[w-1] ? (m & ~(m >> a)) : 64'h0);
      default: r = ((x >> a) | (x << (w - a))) & m;
    endcase
    last = (a == 0) ? 1'b0 : (op == 2'b00) ? x[w-a] : x[a-1];
    return {last, r[31:0]};
  endfunction

  task automatic check(input string tag, input logic [32:0] o, input logic [32:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Called at a negedge with the selected unit idle; returns at the negedge after the handshake
  task automatic run(input bit s, input logic [1:0] op, input logic [31:0] d, input int a, input int hold);
    logic [32:0] exp;
    int k;
    sel = s;
    check("idle_ready", {32'b0, ir}, 33'd1);
    in_valid = 1'b1; in_op = op; in_data = d; in_amt = 5'(a);
    @(posedge clk);
    @(negedge clk);
    if (a > 0) check("busy_ready", {32'b0, ir}, 33'd0);
    k = 0;
    while (!ov && k < 70) begin
      in_valid = 1'($urandom); in_data = $urandom; in_amt = 5'($urandom); in_op = 2'($urandom);
      @(negedge clk);
      k++;
    end
    check("latency", 33'(k), 33'(a));
    exp = model(s ? 32 : 4, d, a, op);
    check("data", {1'b0, od}, {1'b0, exp[31:0]});
    check("last", {32'b0, ol}, {32'b0, exp[32]});
    repeat (hold) begin
      in_valid = 1'b1; in_data = $urandom;
      @(negedge clk);
      check("hold_data", {ol, od}, exp);
      check("hold_valid", {31'b0, ov, ir}, 33'b10);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_idle", {31'b0, ov, ir}, 33'b01);
  endtask

  initial begin
    #1;
    check("rst_out", {ol4, 28'b0, od4}, 33'd0);
    check("rst_flags", {31'b0, ov4, ir4}, 33'b01);
    check("rst_out32", {ol32, od32}, 33'd0);
    @(negedge clk);
    reset = 1'b1;
    run(0, 2'b10, 32'hE, 1, 0);
    run(0, 2'b01, 32'hE, 1, 0);
    run(0, 2'b00, 32'h3, 1, 0);
    run(0, 2'b11, 32'h3, 1, 0);
    for (int i = 0; i < 4; i++) run(0, 2'(i), 32'hA, 0, 0);
    run(0, 2'b00, 32'h9, 3, 0);
    run(0, 2'b10, 32'h9, 3, 5);
    run(1, 2'b10, 32'h8000_0000, 31, 0);
    run(1, 2'b11, 32'h1234_5679, 31, 1);
    run(1, 2'b00, 32'hC000_0001, 31, 0);
    for (int i = 0; i < 20; i++) run(0, 2'($urandom), $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    for (int i = 0; i < 20; i++) run(1, 2'($urandom), $urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
    sel = 1'b0;
    in_valid = 1'b1; in_op = 2'b00; in_data = 32'h1; in_amt = 5'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_out", {ol4, 28'b0, od4}, 33'd0);
    check("abort_valid", {32'b0, ov4}, 33'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("abort_idle", {31'b0, ov4, ir4}, 33'b01);
    end
    run(0, 2'b11, 32'h6, 2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iter_shifter.md
ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width in bits; legal values are powers of two, 4..64.
REQ-002 SHALL have local parameter SHW = log2(WIDTH), meaning shift-amount width.
REQ-003 clk  input  1  sole clock; all state updates occur on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 clears all state.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  unit idle and able to accept a request.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 in_amt  input  SHW  shift amount, 0..WIDTH-1.
REQ-009 in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_data  output  WIDTH  shifted result.
REQ-013 out_last  output  1  last bit shifted out (SLL: old MSB; SRL/SRA: old LSB; ROR: bit rotated into the MSB); 0 when amt=0.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 Accept SHALL occur on an edge with in_valid && in_ready; SHALL capture in_data, in_amt, and in_op.
REQ-017 On accept with in_amt=0, SHALL go to DONE with out_data=in_data and out_last=0.
REQ-018 On accept with in_amt=n>0, SHALL go to SHIFT with counter=n.
REQ-019 Each SHIFT edge SHALL shift the working register by exactly 1 position per in_op, update out_last, and decrement the counter.
REQ-020 In SHIFT, the edge where counter=1 SHALL move the FSM to DONE.
REQ-021 Latency: if accept edge = E0, out_valid SHALL rise immediately after edge E0+amt; one request in flight; no pipelining.
REQ-022 Fill rules:
- SLL SHALL fill the LSB with 0.
- SRL SHALL fill the MSB with 0.
- SRA SHALL replicate the sign bit (bit WIDTH-1) into the MSB.
- ROR SHALL move the LSB into the MSB.
REQ-023 Results SHALL equal the single-cycle operators: data<<amt, data>>amt, $signed(data)>>>amt, rotate-right by amt; the width is exactly WIDTH with no extension.
REQ-024 DONE SHALL hold out_data and out_last stable until out_valid && out_ready; that edge SHALL return the FSM to IDLE.
REQ-025 in_valid SHALL be ignored outside IDLE; inputs changing during SHIFT/DONE SHALL NOT affect the result.
REQ-026 No combinational path SHALL exist from in_valid to in_ready, nor from out_ready to out_valid.
REQ-027 Back-to-back operation: a new accept SHALL be possible on the edge immediately after the DONE handshake, since IDLE lasts ≥1 cycle.
REQ-028 amt=WIDTH-1 SHALL be supported; amounts ≥WIDTH cannot be expressed because in_amt is SHW bits wide.

Reset
REQ-029 reset=0 SHALL force, asynchronously, state=IDLE, counter=0, out_data=0, out_last=0, out_valid=0, and in_ready=1 (after release).
REQ-030 Reset asserted during SHIFT or DONE SHALL abort the operation; no result SHALL be delivered.
REQ-031 The first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-032 Package shifter_pkg SHALL hold the op encodings (OP_SLL, OP_SRL, OP_SRA, OP_ROR) and the state encoding.
REQ-033 One combinational sub-module, shift_step, SHALL implement the parameterised 1-position shift and produce the shifted-out bit; iter_shifter SHALL hold the FSM, the counter, and the registers.

Verification (WIDTH=4 unless stated)
REQ-034 SRA, 4'b1110 amt=1 -> out_data=4'b1111, out_last=0; SRL, same operands -> 4'b0111, out_last=0.
REQ-035 SLL 4'b0011 amt=1 -> 4'b0110, out_last=0; ROR 4'b0011 amt=1 -> 4'b1001, out_last=1.
REQ-036 Any op, amt=0, data 4'b1010 -> out_valid right after the accept edge, out_data=4'b1010, out_last=0.
REQ-037 WIDTH=32, SRA 0x80000000 amt=31 -> 0xFFFFFFFF after 31 SHIFT edges; out_valid rises after edge E0+31.
REQ-038 Backpressure: out_ready=0 for 5 cycles in DONE -> out_data stays stable, in_ready=0, and a new in_valid is ignored; out_ready=1 -> IDLE the next cycle.
REQ-039 reset=0 in mid-SHIFT (SLL 4'b0001 amt=3, after 1 edge) -> outputs 0 immediately and in_ready=1 after release; no out_valid pulse occurs.
